datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Single-clock issue sequencer that turns macro-operations into the 7-bit `ctrl` word stream consumed by the datapath control unit. Each datapath pass uses two consecutive control words: a READ word with operand addresses and operand select, then an EXEC word with the ALU opcode, write address and shift control. Repeated passes let one macro-op apply the same operation N times, for example multi-bit shifts or accumulation into the destination register. The block sits between the instruction source (a testbench or upstream fetch logic) and the `control` block's `ctrl` input.

## Interface
- No parameters; all widths are fixed by the `ctrl` format.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a macro-op is presented.
- `in_ready` output 1: the sequencer accepts the macro-op this cycle; the transfer happens when `in_valid && in_ready`.
- `in_op` input 3: ALU opcode, placed in the EXEC word.
- `in_opsel` input 2: operand select, placed in the READ word.
- `in_srca` input 2: A-port register address.
- `in_srcb` input 2: B-port register address.
- `in_dst` input 2: write register address.
- `in_shift` input 2: bit0 = shift left, bit1 = shift right; the value 11 is illegal and is issued as 00.
- `in_count` input 4: number of passes; the value 0 is treated as 1.
- `ctrl` output 7: control word to the datapath, registered.
- `ctrl_valid` output 1: `ctrl` carries a READ or EXEC word.
- `ctrl_phase` output 1: 0 = READ word, 1 = EXEC word.
- `busy` output 1: a macro-op is in progress.
- `done` output 1: one-cycle pulse, coincident with the final EXEC word of a macro-op.
- `retired` output 8: count of completed macro-ops; wraps from 255 to 0.

## Operation
- **FSM states:** IDLE, READ, EXEC. The state is registered, and so are `ctrl`, `ctrl_valid`, `ctrl_phase` and `done`.
- **READ word:** `ctrl[6]` = 0, `ctrl[5:4]` = opsel, `ctrl[3:2]` = B address, `ctrl[1:0]` = A address.
- **EXEC word:** `ctrl[6:4]` = op, `ctrl[3:2]` = dst, `ctrl[1:0]` = shift, with 11 mapped to 00.
- **Accept:** the macro-op fields are captured into holding registers. The pass counter loads `max(in_count, 1)`.
- **IDLE:**
  - `in_ready` = 1.
  - On accept, go to READ. Otherwise stay; `ctrl` = 0 and `ctrl_valid` = 0.
- **READ:**
  - Emit the READ word, then go to EXEC.
  - `in_ready` = 0.
- **EXEC:**
  - Emit the EXEC word and decrement the pass counter.
  - If passes remain, go to READ.
  - If this is the last pass: pulse `done`, increment `retired`, assert `in_ready` (combinational), and then either go to READ with the new op if an accept occurs, or go to IDLE.
- **Passes after the first:**
  - A address = held dst (accumulate/in-place).
  - B address, opsel, op, dst and shift are unchanged.
  - The first pass uses `in_srca`.
- **Input stability:** `in_*` fields are sampled only at accept. Changes while `in_ready` = 0 are ignored.
- **`busy`** = 1 in READ and EXEC, 0 in IDLE.

## Timing
- **Reset values:** state IDLE, `ctrl` = 7'h00, `ctrl_valid` = 0, `ctrl_phase` = 0, `done` = 0, `busy` = 0, `retired` = 0, pass counter = 0, holding registers = 0, `in_ready` = 1 in the cycle after reset deasserts.
- **Latency:** accept at edge k gives the READ word visible after k+1 and the EXEC word after k+2.
- **Pass cost:** a macro-op of N passes occupies 2N cycles, and `done` goes high in cycle 2N.
- **Back-to-back ops:** an accept during the last EXEC cycle yields the new READ word on the next cycle with no bubble. Sustained throughput is one pass per 2 cycles.
- **Reset priority:** `reset` asserted mid-operation aborts the op at the next edge. No `done` is issued, `retired` is cleared, and all outputs take their reset values.
- **No contention:** `in_valid` while `in_ready` = 0 is held off. No data is lost, because nothing is captured until `in_ready` = 1.
- **`retired` wrap:** 255 plus one completion gives 0, with `done` still pulsed.

## Test plan
- **Reset:** hold `reset` 3 cycles mid-op → all outputs at reset values. `in_ready` = 1 and `ctrl` = 00 afterwards, and `retired` = 0.
- **Single pass:** op = 3'b101, opsel = 2'b10, srca = 1, srcb = 2, dst = 3, shift = 00, count = 1, accepted at cycle 0 → cycle 1 `ctrl` = 7'b0101001 with phase 0; cycle 2 `ctrl` = 7'b1011100 with phase 1 and `done` = 1; cycle 3 `ctrl_valid` = 0.
- **Repeated shift left:** shift = 01, count = 3, srca = 0, dst = 2 → 6 words. The READ A addresses are 0, 2, 2. Each EXEC word ends in 2'b10_01. `done` goes high only on the 6th word.
- **Back-to-back:** two ops presented with `in_valid` held high → the second READ word immediately follows the first op's final EXEC word, `in_ready` is high only in IDLE or in the final EXEC cycle, and `retired` goes up by 2.
- **Edge inputs:** count = 0 → exactly 1 pass. Shift = 11 → EXEC `ctrl[1:0]` = 00.
- **Counter wrap:** 256 single-pass ops → `retired` returns to 0, with 256 `done` pulses.

Source files
------------

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : datapath_sequencer
// Purpose  : Turns macro-operations into a stream of 7-bit datapath control
//            words. Each pass is a READ word (opsel, B addr, A addr) followed
//            by an EXEC word (op, dst, shift). A macro-op repeats its pass
//            in_count times (0 is treated as 1). Passes after the first read
//            the destination register on the A port to accumulate in place.
// Ports    : clk, reset (sync, active-high)
//            in_valid/in_ready handshake; in_op[2:0], in_opsel[1:0],
//            in_srca[1:0], in_srcb[1:0], in_dst[1:0], in_shift[1:0],
//            in_count[3:0] macro-op fields sampled at accept
//            ctrl[6:0], ctrl_valid, ctrl_phase (0 READ / 1 EXEC) - registered
//            busy (op in progress), done (pulse with final EXEC word),
//            retired[7:0] (wrapping count of completed macro-ops)
// Revision : 1.0 - initial release
// ============================================================================
module datapath_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [1:0] in_opsel,
    input  logic [1:0] in_srca,
    input  logic [1:0] in_srcb,
    input  logic [1:0] in_dst,
    input  logic [1:0] in_shift,
    input  logic [3:0] in_count,
    output logic [6:0] ctrl,
    output logic       ctrl_valid,
    output logic       ctrl_phase,
    output logic       busy,
    output logic       done,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    // Holding registers for the macro-op in flight
    logic [2:0] r_op;
    logic [1:0] r_opsel;
    logic [1:0] r_srca;
    logic [1:0] r_srcb;
    logic [1:0] r_dst;
    logic [1:0] r_shift;
    logic [3:0] r_passes;

    logic [6:0] r_ctrl;
    logic       r_ctrl_valid;
    logic       r_ctrl_phase;
    logic       r_done;
    logic [7:0] r_retired;

    logic [6:0] w_ctrl_next;
    logic       w_ctrl_valid_next;
    logic       w_ctrl_phase_next;
    logic       w_done_next;
    logic       w_last;
    logic       w_accept;

    // Final pass: the EXEC word being issued this cycle ends the macro-op, so
    // a new op may be accepted now and start its READ with no bubble.
    assign w_last   = (r_state == S_EXEC) && (r_passes == 4'd1);
    assign in_ready = (r_state == S_IDLE) || w_last;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next control word
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_ctrl_next       = 7'h00;
        w_ctrl_valid_next = 1'b0;
        w_ctrl_phase_next = 1'b0;
        w_done_next       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_ctrl_next       = {1'b0, r_opsel, r_srcb, r_srca};
                w_ctrl_valid_next = 1'b1;
                w_state_next      = S_EXEC;
            end
            S_EXEC: begin
                w_ctrl_next       = {r_op, r_dst, r_shift};
                w_ctrl_valid_next = 1'b1;
                w_ctrl_phase_next = 1'b1;
                if (w_last) begin
                    w_done_next  = 1'b1;
                    w_state_next = w_accept ? S_READ : S_IDLE;
                end else begin
                    w_state_next = S_READ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, holding registers, pass and retire counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl       <= 7'h00;
            r_ctrl_valid <= 1'b0;
            r_ctrl_phase <= 1'b0;
            r_done       <= 1'b0;
            r_retired    <= 8'h00;
            r_op         <= 3'd0;
            r_opsel      <= 2'd0;
            r_srca       <= 2'd0;
            r_srcb       <= 2'd0;
            r_dst        <= 2'd0;
            r_shift      <= 2'd0;
            r_passes     <= 4'd0;
        end else begin
            r_ctrl       <= w_ctrl_next;
            r_ctrl_valid <= w_ctrl_valid_next;
            r_ctrl_phase <= w_ctrl_phase_next;
            r_done       <= w_done_next;

            if (w_accept) begin
                r_op     <= in_op;
                r_opsel  <= in_opsel;
                r_srca   <= in_srca;
                r_srcb   <= in_srcb;
                r_dst    <= in_dst;
                // Simultaneous left+right is meaningless; issue as no shift.
                r_shift  <= (in_shift == 2'b11) ? 2'b00 : in_shift;
                r_passes <= (in_count == 4'd0) ? 4'd1 : in_count;
            end else if (r_state == S_EXEC) begin
                r_passes <= r_passes - 4'd1;
                // Later passes operate on the previous result in place.
                r_srca   <= r_dst;
            end

            if (w_last) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    assign ctrl       = r_ctrl;
    assign ctrl_valid = r_ctrl_valid;
    assign ctrl_phase = r_ctrl_phase;
    assign done       = r_done;
    assign retired    = r_retired;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_sequencer
// Purpose  : Directed self-checking bench for datapath_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_opsel;
    logic [1:0] in_srca;
    logic [1:0] in_srcb;
    logic [1:0] in_dst;
    logic [1:0] in_shift;
    logic [3:0] in_count;
    logic [6:0] ctrl;
    logic       ctrl_valid;
    logic       ctrl_phase;
    logic       busy;
    logic       done;
    logic [7:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    datapath_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_opsel   (in_opsel),
        .in_srca    (in_srca),
        .in_srcb    (in_srcb),
        .in_dst     (in_dst),
        .in_shift   (in_shift),
        .in_count   (in_count),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .ctrl_phase (ctrl_phase),
        .busy       (busy),
        .done       (done),
        .retired    (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [1:0] opsel,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input logic [1:0] sh,
                          input logic [3:0] cnt);
        in_op    = op;
        in_opsel = opsel;
        in_srca  = sa;
        in_srcb  = sb;
        in_dst   = dst;
        in_shift = sh;
        in_count = cnt;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctrl"},  {25'd0, ctrl}, 32'h00);
        chk({tag, "_valid"}, {31'd0, ctrl_valid}, 32'd0);
        chk({tag, "_phase"}, {31'd0, ctrl_phase}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        set_op(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ---------------- Reset state ----------------
        chk_idle_outputs("rst");
        chk("rst_retired", {24'd0, retired}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- Single pass ----------------
        set_op(3'b101, 2'b10, 2'd1, 2'd2, 2'd3, 2'b00, 4'd1);
        in_valid = 1'b1;
        tick();                               // accept
        in_valid = 1'b0;
        set_op(3'b111, 2'b11, 2'd3, 2'd3, 2'd0, 2'b10, 4'd9); // must be ignored
        chk("sp_busy", {31'd0, busy}, 32'd1);
        chk("sp_ready_read", {31'd0, in_ready}, 32'd0);
        chk("sp_valid0", {31'd0, ctrl_valid}, 32'd0);
        tick();
        chk("sp_read", {25'd0, ctrl}, 32'b0101001);
        chk("sp_read_phase", {31'd0, ctrl_phase}, 32'd0);
        chk("sp_read_valid", {31'd0, ctrl_valid}, 32'd1);
        chk("sp_read_done", {31'd0, done}, 32'd0);
        chk("sp_ready_exec", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sp_exec", {25'd0, ctrl}, 32'b1011100);
        chk("sp_exec_phase", {31'd0, ctrl_phase}, 32'd1);
        chk("sp_exec_done", {31'd0, done}, 32'd1);
        chk("sp_retired", {24'd0, retired}, 32'd1);
        tick();
        chk_idle_outputs("sp_after");

        // ---------------- Repeated shift left, 3 passes ----------------
        set_op(3'b010, 2'b01, 2'd0, 2'd1, 2'd2, 2'b01, 4'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk($sformatf("rs_read%0d", p), {25'd0, ctrl},
                {25'd0, 1'b0, 2'b01, 2'd1, (p == 0) ? 2'd0 : 2'd2});
            chk($sformatf("rs_read_phase%0d", p), {31'd0, ctrl_phase}, 32'd0);
            chk($sformatf("rs_read_done%0d", p), {31'd0, done}, 32'd0);
            chk($sformatf("rs_ready%0d", p), {31'd0, in_ready}, (p == 2) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rs_exec%0d", p), {25'd0, ctrl}, 32'b0101001);
            chk($sformatf("rs_exec_phase%0d", p), {31'd0, ctrl_phase}, 32'd1);
            chk($sformatf("rs_exec_done%0d", p), {31'd0, done}, (p == 2) ? 32'd1 : 32'd0);
        end
        chk("rs_retired", {24'd0, retired}, 32'd2);

        // ---------------- Back-to-back, edge inputs on op B ----------------
        set_op(3'b001, 2'b11, 2'd3, 2'd0, 2'd1, 2'b10, 4'd2);
        in_valid = 1'b1;
        tick();                               // accept A
        set_op(3'b110, 2'b00, 2'd2, 2'd3, 2'd0, 2'b11, 4'd0);
        chk("bb_ready_r1", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bb_a_read1", {25'd0, ctrl}, 32'b0110011);
        chk("bb_ready_e1", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bb_a_exec1", {25'd0, ctrl}, 32'b0010110);
        chk("bb_a_done1", {31'd0, done}, 32'd0);
        chk("bb_ready_r2", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bb_a_read2", {25'd0, ctrl}, 32'b0110001);
        chk("bb_ready_e2", {31'd0, in_ready}, 32'd1);
        tick();                               // final EXEC of A, accept B
        in_valid = 1'b0;
        chk("bb_a_exec2", {25'd0, ctrl}, 32'b0010110);
        chk("bb_a_done2", {31'd0, done}, 32'd1);
        chk("bb_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("bb_b_read", {25'd0, ctrl}, 32'b0001110);
        chk("bb_b_valid", {31'd0, ctrl_valid}, 32'd1);
        chk("bb_b_phase", {31'd0, ctrl_phase}, 32'd0);
        tick();
        chk("bb_b_exec", {25'd0, ctrl}, 32'b1100000);
        chk("bb_b_done", {31'd0, done}, 32'd1);
        chk("bb_retired", {24'd0, retired}, 32'd4);
        tick();
        chk("bb_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- Reset mid-op ----------------
        set_op(3'b011, 2'b01, 2'd1, 2'd1, 2'd1, 2'b01, 4'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_idle_outputs("mr");
        chk("mr_retired", {24'd0, retired}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("mr_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_ctrl", {25'd0, ctrl}, 32'h00);
        repeat (4) tick();
        chk("mr_no_done", {31'd0, done}, 32'd0);
        chk("mr_retired2", {24'd0, retired}, 32'd0);

        // ---------------- Retired counter wrap: 256 single-pass ops ----------------
        set_op(3'b100, 2'b00, 2'd0, 2'd1, 2'd2, 2'b00, 4'd1);
        in_valid = 1'b1;
        tick();
        n_done = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (done) n_done++;
            if (i == 255) in_valid = 1'b0;
            tick();
            if (done) n_done++;
            if (i == 254) chk("wr_255", {24'd0, retired}, 32'd255);
        end
        chk("wr_retired", {24'd0, retired}, 32'd0);
        chk("wr_dones", n_done, 32'd256);
        tick();
        chk("wr_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
